corr_bank_dispatch: RTL
=======================

# corr_bank_dispatch

Parametrised bank of square-wave code correlators with windowed match detection and a byte-addressed readback port. An asynchronous 1-bit input `sig` is compared against N_CH internally generated codes over a fixed window. Each channel's match result is latched once per window and exposed over the existing addr_latch/data_in/data_out host bus. A ready/overrun handshake tells the host when fresh results are available.

## Interface
- `N_CH`, 16: channel count; must be a multiple of 8, at most 64.
- `WINDOW`, 2048: integration window length in clk cycles; must be at least 2.
- `THRESHOLD`, 16'h0450: a channel matches when its agree count is ≥ THRESHOLD.
- `HP_BASE`, 4: half period of group 0 codes in cycles; must be at least 4.
- `clk  in  1`: single clock, rising edge.
- `rst_in_n  in  1`: asynchronous, active-low reset.
- `sig  in  1`: raw input signal; asynchronous to clk.
- `addr_latch  in  1`: on the edge where this is high, `data_in` is written to `addr_reg`.
- `data_in  in  8`: address or command byte.
- `data_out  out  8`: read data selected by `addr_reg` (combinational decode of registered state).
- `rdy  out  1`: high while an unread result set is held.

## Operation
- **Input sync:** `sig` passes through a 2-flop synchroniser to give `sig_s`. Only `sig_s` is used internally.
- **Code generators:** one per channel k.
  - Group g = k>>2. Phase p = k%4. Half period hp_k = HP_BASE + g.
  - Counter c_k runs 0..hp_k−1. On the edge where c_k == hp_k−1, `code_k` toggles and c_k goes to 0.
  - At reset and at every window restart: c_k <= p and code_k <= 0.
- **Window counter:** `wctr` runs 0..WINDOW−1 and wraps to 0. The last cycle of a window is wctr == WINDOW−1.
- **Accumulators:** `agree_k` has width clog2(WINDOW+1).
  - It increments in every cycle where sig_s == code_k.
  - It counts cycles 0..WINDOW−1 inclusive and cannot overflow.
- **Window end** (edge leaving wctr == WINDOW−1), all of the following happen on that edge:
  - `res[k]` <= (agree_k + this cycle's agreement) ≥ THRESHOLD.
  - All agree_k <= 0, and the code generators reload.
  - `rdy` <= 1.
  - If rdy was already 1, sticky `ovr` <= 1.
  - `win_cnt` (8-bit) increments and wraps at 255 to 0.
- **Readback map** for `addr_reg`:
  - 0..N_CH/8−1: res[8a+7:8a].
  - 0x3F: status {ovr, 3'b0, win_cnt[3:0]}.
  - 0x40..0x40+N_CH−1: hit counters (see Configuration).
  - All other addresses read 8'h00.
- **Handshake:**
  - Any addr_latch edge clears rdy, unless a window end occurs on the same edge; set wins.
  - addr_latch with data_in == 8'hFE clears ovr and all hit counters. The same edge writes 0xFE to addr_reg, which reads 0.
  - If that clear coincides with a window end, the new ovr value is taken (set wins). Hit counters clear and then take this window's increment.

## Timing
- Reset values: `addr_reg`=0, `res`=0, `rdy`=0, `ovr`=0, `win_cnt`=0, `wctr`=0, all agree_k=0, all code_k=0, c_k=k%4, sync flops=0. data_out therefore resets to 8'h00.
- Reset mid-window discards the partial window. No result is latched.
- A `sig` change reaches the agree logic 2 cycles later.
- data_out reflects a new addr_reg in the cycle after the addr_latch edge.
- data_out reflects new res in the cycle after the window-end edge.
- rdy rises one edge after the last window cycle and falls one edge after the addr_latch edge.
- The first window after reset ends on the edge at the end of cycle WINDOW−1, i.e. WINDOW edges after reset release.

## Configuration
- **`CORR_HITCNT_EN` defined:** each channel has an 8-bit saturating hit counter.
  - It increments (saturating at 8'hFF) at each window end where res[k] is set.
  - It reads at 0x40+k.
  - It is cleared by the 0xFE command and by reset.
- **Not defined:** no counters are built, addresses 0x40.. read 8'h00, and 0xFE clears ovr only.

## Test plan
- **Reset defaults:** assert rst_in_n low mid-window, release, then latch address 0x3F -> data_out=8'h00 and rdy=0; rdy rises exactly WINDOW edges after release.
- **Null input:** WINDOW=2048, THRESHOLD=0x450, sig held 0 -> every agree_k ≈1024 < 1104. At address 0 and address 1, data_out=8'h00; rdy=1 after the first window.
- **Single-channel match:** WINDOW=64, THRESHOLD=60, sig = the channel 5 code (hp=5, phase 1) driven 2 cycles early -> address 0 reads 8'h20 and address 1 reads 8'h00.
- **Overrun:** let 2 windows end without addr_latch -> status bit7=1 and win_cnt[3:0]=2. Latch 0xFE -> bit7=0 on the next readback of 0x3F.
- **Simultaneous events:** addr_latch on the exact window-end edge -> rdy stays 1 and ovr is unaffected by the read.
- **Hit counters** (CORR_HITCNT_EN): channel 5 matched for 300 windows -> address 0x45 reads 8'hFF. After 0xFE, it reads 8'h00.

Source files
------------

// File: rtl/corr_bank_dispatch.sv
// corr_bank_dispatch
// Bank of N_CH square-wave code correlators. Every WINDOW cycles, each channel
// reports whether the synchronised input agreed with its code for at least
// THRESHOLD cycles. Results, a status byte and optional hit counters are read
// back over the addr_latch/data_in/data_out byte bus.
// Optional feature macro: CORR_HITCNT_EN builds one 8-bit saturating hit counter
// per channel, readable at 0x40+k.
module corr_bank_dispatch #(
   parameter int          N_CH      = 16,
   parameter int          WINDOW    = 2048,
   parameter logic [15:0] THRESHOLD = 16'h0450,
   parameter int          HP_BASE   = 4
) (
   input  logic       clk,
   input  logic       rst_in_n,
   input  logic       sig,
   input  logic       addr_latch,
   input  logic [7:0] data_in,
   output logic [7:0] data_out,
   output logic       rdy
);

   localparam int AW = $clog2(WINDOW + 1);
   localparam int WW = $clog2(WINDOW);
   localparam int CW = $clog2(HP_BASE + N_CH / 4);
   localparam int NB = N_CH / 8;

   localparam logic [7:0] CMD_CLR   = 8'hFE;
   localparam logic [7:0] ADDR_STAT = 8'h3F;

   logic            r_sync1;
   logic            r_sync2;
   logic [WW-1:0]   r_wctr;
   logic            w_win_end;
   logic            w_clr;

   logic [CW-1:0]   r_cnt   [N_CH];
   logic [N_CH-1:0] r_code;
   logic [AW-1:0]   r_agree [N_CH];
   logic [N_CH-1:0] w_agree;
   logic [N_CH-1:0] w_res_nxt;

   logic [N_CH-1:0] r_res;
   logic            r_rdy;
   logic            r_ovr;
   logic [7:0]      r_win_cnt;
   logic [7:0]      r_addr;
   logic [7:0]      w_rd;
   logic            w_unused_wincnt;

   assign w_win_end       = (r_wctr == WW'(WINDOW - 1));
   assign w_clr           = addr_latch && (data_in == CMD_CLR);
   assign w_unused_wincnt = ^r_win_cnt[7:4];

   // two-flop synchroniser for the asynchronous input
   always_ff @(posedge clk or negedge rst_in_n) begin
      if (!rst_in_n) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= sig;
         r_sync2 <= r_sync1;
      end
   end

   // per-channel agreement this cycle and the result if the window closed now
   always_comb begin
      w_agree   = '0;
      w_res_nxt = '0;
      for (int k = 0; k < N_CH; k++) begin
         w_agree[k]   = (r_sync2 == r_code[k]);
         w_res_nxt[k] = (32'(r_agree[k]) + 32'(w_agree[k])) >= 32'(THRESHOLD);
      end
   end

   // code generators and agree accumulators; both restart at every window end
   always_ff @(posedge clk or negedge rst_in_n) begin
      if (!rst_in_n) begin
         for (int k = 0; k < N_CH; k++) begin
            r_cnt[k]   <= CW'(k % 4);
            r_code[k]  <= 1'b0;
            r_agree[k] <= '0;
         end
      end else if (w_win_end) begin
         for (int k = 0; k < N_CH; k++) begin
            r_cnt[k]   <= CW'(k % 4);
            r_code[k]  <= 1'b0;
            r_agree[k] <= '0;
         end
      end else begin
         for (int k = 0; k < N_CH; k++) begin
            if (r_cnt[k] == CW'(HP_BASE + k / 4 - 1)) begin
               r_cnt[k]  <= '0;
               r_code[k] <= ~r_code[k];
            end else begin
               r_cnt[k] <= r_cnt[k] + 1'b1;
            end
            if (w_agree[k])
               r_agree[k] <= r_agree[k] + 1'b1;
         end
      end
   end

   // window counter, result latch, handshake and host address register
   always_ff @(posedge clk or negedge rst_in_n) begin
      if (!rst_in_n) begin
         r_wctr    <= '0;
         r_res     <= '0;
         r_rdy     <= 1'b0;
         r_ovr     <= 1'b0;
         r_win_cnt <= 8'h00;
         r_addr    <= 8'h00;
      end else begin
         r_wctr <= w_win_end ? '0 : r_wctr + 1'b1;
         if (w_win_end) begin
            r_res     <= w_res_nxt;
            r_win_cnt <= r_win_cnt + 1'b1;
         end
         // a window end outranks the host read that would clear rdy
         if (w_win_end)
            r_rdy <= 1'b1;
         else if (addr_latch)
            r_rdy <= 1'b0;
         // overrun set outranks the clear command
         if (w_win_end && r_rdy)
            r_ovr <= 1'b1;
         else if (w_clr)
            r_ovr <= 1'b0;
         if (addr_latch)
            r_addr <= data_in;
      end
   end

`ifdef CORR_HITCNT_EN
   logic [7:0] r_hit [N_CH];

   // saturating per-channel hit counters; a clear still takes this window's hit
   always_ff @(posedge clk or negedge rst_in_n) begin
      if (!rst_in_n) begin
         for (int k = 0; k < N_CH; k++)
            r_hit[k] <= 8'h00;
      end else begin
         for (int k = 0; k < N_CH; k++) begin
            if (w_clr)
               r_hit[k] <= (w_win_end && w_res_nxt[k]) ? 8'h01 : 8'h00;
            else if (w_win_end && w_res_nxt[k] && (r_hit[k] != 8'hFF))
               r_hit[k] <= r_hit[k] + 1'b1;
         end
      end
   end
`endif

   // readback decode of registered state
   always_comb begin
      w_rd = 8'h00;
      for (int a = 0; a < NB; a++)
         if (r_addr == 8'(a))
            w_rd = r_res[8*a +: 8];
      if (r_addr == ADDR_STAT)
         w_rd = {r_ovr, 3'b000, r_win_cnt[3:0]};
`ifdef CORR_HITCNT_EN
      for (int k = 0; k < N_CH; k++)
         if (r_addr == 8'(64 + k))
            w_rd = r_hit[k];
`endif
   end

   assign data_out = w_rd;
   assign rdy      = r_rdy;

endmodule
